// File: rtl/hypot_arbiter.sv
// ---------------------------------------------------------------------------
// hypot_arbiter
//
// Shares one free-running, pipelined hypot unit among N requesters. Each
// cycle at most one valid requester is granted round-robin. Its (x, y) pair
// is registered towards the hypot sink. Its index travels down a tag delay
// line whose depth matches the hypot latency. When the tag reaches the end,
// the hypot result is registered out together with the requester index.
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   enable      low blocks new grants; in-flight work still drains
//   req_valid   [N]        request pending per requester
//   req_x/req_y [N*WIDTH]  signed operands, requester i in [i*WIDTH +: WIDTH]
//   req_ready   [N]        combinational one-hot (or zero) grant
//   hyp_x/hyp_y [WIDTH]    registered operands to the hypot sink
//   hyp_result  [WIDTH]    result from the hypot source
//   res_valid              registered result strobe
//   res_id      [IDW]      registered requester index of the result
//   res_data    [WIDTH]    registered hypot result
//   in_flight   [CW]       accepted but not yet returned requests
// ---------------------------------------------------------------------------
module hypot_arbiter #(
    parameter int N       = 4,
    parameter int WIDTH   = 16,
    parameter int LATENCY = 9,
    localparam int IDW    = ($clog2(N) > 1) ? $clog2(N) : 1,
    localparam int CW     = $clog2(LATENCY + 2)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N-1:0]         req_valid,
    input  logic [N*WIDTH-1:0]   req_x,
    input  logic [N*WIDTH-1:0]   req_y,
    output logic [N-1:0]         req_ready,
    output logic [WIDTH-1:0]     hyp_x,
    output logic [WIDTH-1:0]     hyp_y,
    input  logic [WIDTH-1:0]     hyp_result,
    output logic                 res_valid,
    output logic [IDW-1:0]       res_id,
    output logic [WIDTH-1:0]     res_data,
    output logic [CW-1:0]        in_flight
);

    logic [IDW-1:0] ptr;
    logic           grant_any;
    logic [IDW-1:0] grant_id;

    // Stage 0 moves in lockstep with hyp_x/hyp_y. The LATENCY stages after
    // it cover the hypot pipeline. So the last stage lines up with the edge
    // where hyp_result belongs to that tag.
    logic           tag_v  [0:LATENCY];
    logic [IDW-1:0] tag_id [0:LATENCY];
    logic           tag_out;

    assign tag_out = tag_v[LATENCY];

    // Round-robin search starting at ptr. req_ready depends only on the
    // valids, the pointer, enable and reset. It never depends on the operands.
    always_comb begin
        logic [IDW-1:0] idx;
        grant_any = 1'b0;
        grant_id  = '0;
        req_ready = '0;
        idx       = '0;
        if (enable && !reset) begin
            for (int k = 0; k < N; k++) begin
                idx = IDW'((int'(ptr) + k) % N);
                if (!grant_any && req_valid[idx]) begin
                    grant_any = 1'b1;
                    grant_id  = idx;
                end
            end
            if (grant_any) begin
                req_ready[grant_id] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            hyp_x     <= '0;
            hyp_y     <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
            in_flight <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                tag_v[k]  <= 1'b0;
                tag_id[k] <= '0;
            end
        end else begin
            if (grant_any) begin
                ptr   <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);
                hyp_x <= req_x[int'(grant_id)*WIDTH +: WIDTH];
                hyp_y <= req_y[int'(grant_id)*WIDTH +: WIDTH];
            end else begin
                hyp_x <= '0;
                hyp_y <= '0;
            end

            tag_v[0]  <= grant_any;
            tag_id[0] <= grant_any ? grant_id : '0;
            for (int k = 1; k <= LATENCY; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end

            // Stale hypot results (e.g. after a reset flush) carry no tag
            // and are dropped here.
            res_valid <= tag_out;
            res_id    <= tag_id[LATENCY];
            res_data  <= tag_out ? hyp_result : '0;

            // The counter drops on the same edge that raises res_valid.
            // It is bounded by LATENCY+1 because of the pipeline depth.
            case ({grant_any, tag_out})
                2'b10:   in_flight <= in_flight + CW'(1);
                2'b01:   in_flight <= in_flight - CW'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

endmodule

// File: tb/tb_hypot_arbiter.sv
module tb_hypot_arbiter;

    localparam int N       = 4;
    localparam int WIDTH   = 16;
    localparam int LATENCY = 9;
    localparam int IDW     = 2;
    localparam int CW      = $clog2(LATENCY + 2);

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic [N-1:0]       req_valid = '0;
    logic [N*WIDTH-1:0] req_x = '0;
    logic [N*WIDTH-1:0] req_y = '0;
    logic [N-1:0]       req_ready;
    logic [WIDTH-1:0]   hyp_x, hyp_y, hyp_result, res_data;
    logic               res_valid;
    logic [IDW-1:0]     res_id;
    logic [CW-1:0]      in_flight;

    hypot_arbiter #(.N(N), .WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_ready(req_ready), .hyp_x(hyp_x), .hyp_y(hyp_y),
        .hyp_result(hyp_result), .res_valid(res_valid), .res_id(res_id),
        .res_data(res_data), .in_flight(in_flight)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   m_ptr = 0;
    int   max_if = 0;
    int   last_id = -1;
    int   last_data = -1;
    logic [WIDTH-1:0] nxt_hx = '0, nxt_hy = '0, cur_hx = '0, cur_hy = '0;

    // Floor of sqrt(x^2 + y^2) for signed operands, truncated to WIDTH bits.
    function automatic logic [WIDTH-1:0] hyp_ref(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        longint xs, ys, s, r, t;
        xs = longint'($signed(x));
        ys = longint'($signed(y));
        s  = xs*xs + ys*ys;
        r  = 0;
        for (int b = WIDTH + 1; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t*t <= s) r = t;
        end
        return WIDTH'(r);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural hypot unit. It samples the sink on the edge after the issue
    // edge. The result is presented after E0+LATENCY. It is not reset.
    logic [WIDTH-1:0] hp [LATENCY];
    initial foreach (hp[k]) hp[k] = '0;
    always @(posedge clk) begin
        hp[0] <= hyp_ref(hyp_x, hyp_y);
        for (int k = 1; k < LATENCY; k++) hp[k] <= hp[k-1];
    end
    assign hyp_result = hp[LATENCY-1];

    always @(posedge clk) begin
        cyc++;
        cur_hx <= nxt_hx;
        cur_hy <= nxt_hy;
    end

    // Predictor: round-robin grant rule. Expected results are pushed to the
    // scoreboard with the cycle they are due.
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int g;
        int idx;
        exp_t e;
        exp_rdy = '0;
        g = -1;
        if (!reset && enable) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (g >= 0) begin
            e.id   = g;
            e.data = hyp_ref(req_x[g*WIDTH +: WIDTH], req_y[g*WIDTH +: WIDTH]);
            e.due  = cyc + LATENCY + 2;
            q.push_back(e);
            m_ptr  = (g + 1) % N;
            nxt_hx = req_x[g*WIDTH +: WIDTH];
            nxt_hy = req_y[g*WIDTH +: WIDTH];
        end else begin
            nxt_hx = '0;
            nxt_hy = '0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        exp_t e;
        int exp_if;
        if (res_valid) begin
            last_id   = int'(res_id);
            last_data = int'(res_data);
            if (q.size() == 0) begin
                chk("unexpected_result", 64'(res_valid), 64'(0));
            end else begin
                e = q.pop_front();
                chk("res_id", 64'(res_id), 64'(e.id));
                chk("res_data", 64'(res_data), 64'(e.data));
                chk("res_latency", 64'(cyc), 64'(e.due));
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            chk("missing_result", 64'(res_valid), 64'(1));
            void'(q.pop_front());
        end
        exp_if = 0;
        foreach (q[k]) if (q[k].due - LATENCY - 1 <= cyc) exp_if++;
        chk("in_flight", 64'(in_flight), 64'(exp_if));
        chk("hyp_x", 64'(hyp_x), reset ? 64'(0) : 64'(cur_hx));
        chk("hyp_y", 64'(hyp_y), reset ? 64'(0) : 64'(cur_hy));
        if (int'(in_flight) > max_if) max_if = int'(in_flight);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        req_x[i*WIDTH +: WIDTH] = x;
        req_y[i*WIDTH +: WIDTH] = y;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 60) begin
            step();
            t++;
        end
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'(0));
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        repeat (3) step();
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_res_id", 64'(res_id), 64'(0));
        chk("rst_res_data", 64'(res_data), 64'(0));
        chk("rst_in_flight", 64'(in_flight), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        reset  = 1'b0;
        enable = 1'b1;
        step();

        // Single request: requester 2 with (3, 4).
        set_op(2, 16'd3, 16'd4);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        drain();
        chk("single_id", 64'(last_id), 64'(2));
        chk("single_data", 64'(last_data), 64'(5));

        // All four valid continuously, x = i+1, y = 0.
        for (int i = 0; i < N; i++) set_op(i, WIDTH'(i + 1), 16'd0);
        max_if = 0;
        req_valid = '1;
        repeat (24) step();
        req_valid = '0;
        drain();
        chk("in_flight_peak", 64'(max_if), 64'(LATENCY + 1));

        // Extreme operands.
        set_op(1, 16'h8000, 16'd0);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        drain();
        chk("neg_full_scale", 64'(last_data), 64'(32768));
        set_op(3, -16'sd6, 16'sd8);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        drain();
        chk("neg_6_8", 64'(last_data), 64'(10));

        // enable low with everything valid, then rising.
        for (int i = 0; i < N; i++) set_op(i, WIDTH'(100 + i), WIDTH'(7));
        enable = 1'b0;
        req_valid = '1;
        repeat (6) step();
        chk("enable_low_hyp_x", 64'(hyp_x), 64'(0));
        enable = 1'b1;
        repeat (2) step();
        req_valid = '0;
        drain();

        // Reset while three requests are in flight.
        set_op(1, 16'd7, 16'd0);
        req_valid = 4'b0010;
        repeat (3) step();
        req_valid = '0;
        repeat (4) step();
        reset = 1'b1;
        q.delete();
        m_ptr = 0;
        #1;
        chk("flush_res_valid", 64'(res_valid), 64'(0));
        chk("flush_hyp_x", 64'(hyp_x), 64'(0));
        chk("flush_in_flight", 64'(in_flight), 64'(0));
        chk("flush_req_ready", 64'(req_ready), 64'(0));
        step();
        step();
        reset = 1'b0;
        repeat (15) step();
        for (int i = 0; i < N; i++) set_op(i, WIDTH'(i * 3), WIDTH'(i * 4));
        req_valid = '1;
        step();
        req_valid = '0;
        drain();
        chk("post_reset_grant", 64'(last_id), 64'(0));

        // Random traffic.
        for (int c = 0; c < 10000; c++) begin
            enable = ($urandom_range(0, 9) != 0);
            req_valid = N'($urandom_range(0, 15)) | (($urandom_range(0, 1) != 0) ? N'($urandom_range(0, 15)) : '0);
            for (int i = 0; i < N; i++) set_op(i, WIDTH'($urandom), WIDTH'($urandom));
            step();
        end
        req_valid = '0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
